// File: rtl/plic_gateway.sv
// Per-source PLIC interrupt gateway: turns raw lines into a single-outstanding ip vector.
// Define PLIC_GATEWAY_SYNC_EN to insert a 2-flop synchronizer ahead of the input stage.
module plic_gateway #(
    parameter int SOURCES           = 8,
    parameter int TARGETS           = 1,
    parameter int SOURCES_BITS      = 4,
    parameter int MAX_PENDING_COUNT = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [SOURCES-1:0]              src,
    input  logic [SOURCES-1:0]              el,
    output logic [SOURCES-1:0]              ip,
    input  logic [TARGETS-1:0]              claim,
    input  logic [TARGETS*SOURCES_BITS-1:0] claim_id,
    input  logic [TARGETS-1:0]              complete,
    input  logic [TARGETS*SOURCES_BITS-1:0] complete_id
);

    localparam int CNT_W = $clog2(MAX_PENDING_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

    logic [SOURCES-1:0] s_d;
    logic [SOURCES-1:0] s_q;
    logic [SOURCES-1:0] s_prev_q;
    logic [SOURCES-1:0] rise;
    logic [SOURCES-1:0] claim_hit;
    logic [SOURCES-1:0] complete_hit;

`ifdef PLIC_GATEWAY_SYNC_EN
    localparam int VLD_DEPTH = 4;
    logic [SOURCES-1:0] sync1_q;
    logic [SOURCES-1:0] sync2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign s_d = sync2_q;
`else
    localparam int VLD_DEPTH = 2;
    assign s_d = src;
`endif

    // vld_q fills with ones once s_prev_q holds a genuine post-reset sample, so a
    // line that was already high across reset is not mistaken for a fresh edge.
    logic [VLD_DEPTH-1:0] vld_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_q      <= '0;
            s_prev_q <= '0;
            vld_q    <= '0;
        end else begin
            s_q      <= s_d;
            s_prev_q <= s_q;
            vld_q    <= {vld_q[VLD_DEPTH-2:0], 1'b1};
        end
    end

    assign rise = s_q & ~s_prev_q & {SOURCES{vld_q[VLD_DEPTH-1]}};

    // IDs 0 and > SOURCES match no source and therefore fall out naturally.
    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        for (int i = 0; i < SOURCES; i++) begin
            for (int t = 0; t < TARGETS; t++) begin
                if (claim[t] && claim_id[t*SOURCES_BITS +: SOURCES_BITS] == SOURCES_BITS'(i + 1))
                    claim_hit[i] = 1'b1;
                if (complete[t] && complete_id[t*SOURCES_BITS +: SOURCES_BITS] == SOURCES_BITS'(i + 1))
                    complete_hit[i] = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < SOURCES; gi++) begin : g_src
        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             req;
        logic             take;

        assign req = el[gi] ? (cnt_q != '0) : s_q[gi];

        always_comb begin
            state_d = state_q;
            take    = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_d = ST_PEND;
                        take    = el[gi];
                    end
                end
                ST_PEND: begin
                    if (claim_hit[gi])
                        state_d = ST_BUSY;
                end
                ST_BUSY: begin
                    // A same-cycle claim makes the complete contradictory; drop it.
                    if (complete_hit[gi] && !claim_hit[gi])
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_comb begin
            cnt_d = cnt_q;
            if (!el[gi])
                cnt_d = '0;
            else if (rise[gi] && take)
                cnt_d = cnt_q;
            else if (rise[gi])
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            else if (take)
                cnt_d = cnt_q - 1'b1;
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign ip[gi] = (state_q == ST_PEND);
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed-sequence bench for plic_gateway with two targets; expected ip vectors go
// through a scoreboard queue and are checked one cycle after being driven.
module tb_plic_gateway;

`ifdef PLIC_GATEWAY_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] src;
    logic [7:0] el;
    logic [7:0] ip;
    logic [1:0] claim;
    logic [7:0] claim_id;
    logic [1:0] complete;
    logic [7:0] complete_id;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string      tag;
        logic [7:0] ip;
    } exp_t;

    exp_t sb[$];

    plic_gateway #(
        .SOURCES(8), .TARGETS(2), .SOURCES_BITS(4), .MAX_PENDING_COUNT(8)
    ) dut (
        .clk(clk), .rstn(rstn), .src(src), .el(el), .ip(ip),
        .claim(claim), .claim_id(claim_id),
        .complete(complete), .complete_id(complete_id)
    );

    always #5 clk = ~clk;

    task automatic check_now();
        exp_t x;
        x = sb.pop_front();
        compared++;
        $display("txn %-16s ip=%h exp=%h", x.tag, ip, x.ip);
        assert (ip === x.ip) else begin
            mismatched++;
            $error("FAIL %s: ip observed %h expected %h", x.tag, ip, x.ip);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] e);
        sb.push_back('{tag, e});
        @(posedge clk);
        #1;
        check_now();
        claim    = '0;
        complete = '0;
    endtask

    task automatic cc(input logic [1:0] cv, input logic [3:0] c0, input logic [3:0] c1,
                      input logic [1:0] pv, input logic [3:0] p0, input logic [3:0] p1);
        claim       = cv;
        claim_id    = {c1, c0};
        complete    = pv;
        complete_id = {p1, p0};
    endtask

    task automatic pulse0(input string tag, input logic [7:0] e);
        src[0] = 1'b1;
        cyc(tag, e);
        src[0] = 1'b0;
        cyc(tag, e);
    endtask

    initial begin
        rstn = 1'b0; src = '0; el = '0;
        claim = '0; claim_id = '0; complete = '0; complete_id = '0;
        cyc("reset", 8'h00);
        cyc("reset", 8'h00);
        rstn = 1'b1;

        // Level source 3
        src[2] = 1'b1;
        cyc("lvl_lat", 8'h00);
        repeat (EXTRA) cyc("lvl_sync", 8'h00);
        cyc("lvl_rise", 8'h04);
        cc(2'b01, 4'd3, 4'd0, 2'b00, 4'd0, 4'd0); cyc("claim3", 8'h00);
        cyc("busy_hold", 8'h00);
        cc(2'b00, 4'd0, 4'd0, 2'b01, 4'd3, 4'd0); cyc("complete3", 8'h00);
        cyc("lvl_rereq", 8'h04);

        // Invalid claims/completes
        cc(2'b11, 4'd0, 4'd9, 2'b00, 4'd0, 4'd0); cyc("claim_id0_9", 8'h04);
        cc(2'b00, 4'd0, 4'd0, 2'b01, 4'd3, 4'd0); cyc("complete_pend", 8'h04);
        cc(2'b01, 4'd1, 4'd0, 2'b00, 4'd0, 4'd0); cyc("claim_idle", 8'h04);
        cc(2'b01, 4'd3, 4'd0, 2'b00, 4'd0, 4'd0); cyc("claim3_b", 8'h00);
        src[2] = 1'b0;
        repeat (EXTRA + 1) cyc("lvl_drop", 8'h00);
        cc(2'b00, 4'd0, 4'd0, 2'b01, 4'd3, 4'd0); cyc("cmp_dropped", 8'h00);
        cyc("lvl_no_rereq", 8'h00);

        // Two targets on source 5
        src[4] = 1'b1;
        cyc("s5_lat", 8'h00);
        repeat (EXTRA) cyc("s5_sync", 8'h00);
        cyc("s5_rise", 8'h10);
        cc(2'b11, 4'd5, 4'd5, 2'b00, 4'd0, 4'd0); cyc("dual_claim", 8'h00);
        cc(2'b00, 4'd0, 4'd0, 2'b11, 4'd5, 4'd5); cyc("dual_complete", 8'h00);
        cyc("s5_rereq", 8'h10);
        cc(2'b01, 4'd5, 4'd0, 2'b10, 4'd0, 4'd5); cyc("cc_pend", 8'h00);
        cc(2'b01, 4'd5, 4'd0, 2'b10, 4'd0, 4'd5); cyc("cc_busy", 8'h00);
        cyc("cc_busy_hold", 8'h00);
        cc(2'b00, 4'd0, 4'd0, 2'b10, 4'd0, 4'd5); cyc("s5_cmp", 8'h00);
        cyc("s5_rereq2", 8'h10);
        src[4] = 1'b0;
        cc(2'b10, 4'd0, 4'd5, 2'b00, 4'd0, 4'd0); cyc("s5_claim", 8'h00);
        repeat (EXTRA + 1) cyc("s5_drop", 8'h00);
        cc(2'b00, 4'd0, 4'd0, 2'b01, 4'd5, 4'd0); cyc("s5_cmp_idle", 8'h00);
        cyc("s5_quiet", 8'h00);

        // Edge counting on source 1
        el = 8'h01;
        pulse0("edge_p0", 8'h00);
        repeat (EXTRA) cyc("edge_sync", 8'h00);
        cyc("edge_first", 8'h01);
        cc(2'b01, 4'd1, 4'd0, 2'b00, 4'd0, 4'd0); cyc("edge_claim0", 8'h00);
        repeat (3) pulse0("edge_busy_p", 8'h00);
        repeat (EXTRA) cyc("edge_settle", 8'h00);
        for (int r = 1; r <= 4; r++) begin
            cc(2'b00, 4'd0, 4'd0, 2'b01, 4'd1, 4'd0); cyc("edge_cmp", 8'h00);
            cyc($sformatf("edge_round%0d", r), (r <= 3) ? 8'h01 : 8'h00);
            if (r <= 3) begin
                cc(2'b01, 4'd1, 4'd0, 2'b00, 4'd0, 4'd0); cyc("edge_claim", 8'h00);
            end
        end

        // Saturation: 12 pulses, 8 served
        pulse0("sat_p0", 8'h00);
        repeat (EXTRA) cyc("sat_sync", 8'h00);
        cyc("sat_first", 8'h01);
        cc(2'b01, 4'd1, 4'd0, 2'b00, 4'd0, 4'd0); cyc("sat_claim0", 8'h00);
        repeat (12) pulse0("sat_busy_p", 8'h00);
        repeat (EXTRA) cyc("sat_settle", 8'h00);
        for (int r = 1; r <= 9; r++) begin
            cc(2'b00, 4'd0, 4'd0, 2'b01, 4'd1, 4'd0); cyc("sat_cmp", 8'h00);
            cyc($sformatf("sat_round%0d", r), (r <= 8) ? 8'h01 : 8'h00);
            if (r <= 8) begin
                cc(2'b01, 4'd1, 4'd0, 2'b00, 4'd0, 4'd0); cyc("sat_claim", 8'h00);
            end
        end

        // Rise coinciding with the IDLE->PEND decrement
        pulse0("dec_p0", 8'h00);
        repeat (EXTRA) cyc("dec_sync", 8'h00);
        cyc("dec_first", 8'h01);
        cc(2'b01, 4'd1, 4'd0, 2'b00, 4'd0, 4'd0); cyc("dec_claim0", 8'h00);
        pulse0("dec_busy_p", 8'h00);
        repeat (EXTRA) cyc("dec_settle", 8'h00);
        src[0] = 1'b1;
        cc(2'b00, 4'd0, 4'd0, 2'b01, 4'd1, 4'd0); cyc("dec_cmp", 8'h00);
        src[0] = 1'b0;
        cyc("dec_pend", 8'h01);
        cc(2'b01, 4'd1, 4'd0, 2'b00, 4'd0, 4'd0); cyc("dec_claim", 8'h00);
        repeat (EXTRA) cyc("dec_settle2", 8'h00);
        cc(2'b00, 4'd0, 4'd0, 2'b01, 4'd1, 4'd0); cyc("dec_cmp2", 8'h00);
        cyc("dec_extra", 8'h01);
        cc(2'b01, 4'd1, 4'd0, 2'b00, 4'd0, 4'd0); cyc("dec_claim2", 8'h00);
        cc(2'b00, 4'd0, 4'd0, 2'b01, 4'd1, 4'd0); cyc("dec_cmp3", 8'h00);
        cyc("dec_empty", 8'h00);

        // Reset with sources busy, pending and counted
        src[2] = 1'b1;
        cyc("r_lat", 8'h00);
        repeat (EXTRA) cyc("r_sync", 8'h00);
        cyc("r_s3", 8'h04);
        cc(2'b01, 4'd3, 4'd0, 2'b00, 4'd0, 4'd0); cyc("r_claim3", 8'h00);
        pulse0("r_p0", 8'h00);
        repeat (EXTRA) cyc("r_sync0", 8'h00);
        cyc("r_s1", 8'h01);
        cc(2'b01, 4'd1, 4'd0, 2'b00, 4'd0, 4'd0); cyc("r_claim1", 8'h00);
        pulse0("r_busy_p", 8'h00);
        src[4] = 1'b1;
        cyc("r_lat5", 8'h00);
        repeat (EXTRA) cyc("r_sync5", 8'h00);
        cyc("r_s5", 8'h10);
        rstn = 1'b0;
        #1;
        sb.push_back('{"rst_async", 8'h00});
        check_now();
        src[1] = 1'b1;
        el = 8'h03;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc("rst_rel", 8'h00);
        repeat (EXTRA) cyc("rst_sync", 8'h00);
        cyc("rst_rereq", 8'h14);
        repeat (4) cyc("rst_no_edge", 8'h14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
